// File: rtl/seg_pkg.sv
// seg_pkg -- shared definitions for the seven-segment scan driver.
//   SEG_DIGITS : bits 6:0 (g..a) for the decimal digits 0..9
//   SEG_DASH / SEG_ERR / SEG_OFF : special full-byte segment patterns
//   slot_state_e : scan slot phase (BLANK dead time, ON drive window)
//   seg_encode() : 4-bit digit -> 7-bit pattern, dark for 10..15
package seg_pkg;

    // Entry i is the pattern for digit i (entry 0 is the rightmost element).
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_ERR  = 8'h79;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] r;
        r = SEG_OFF[6:0];
        if (v <= 4'd9) begin
            r = SEG_DIGITS[v];
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_bin2dec.sv
// seg_bin2dec -- splits a 7-bit binary field into decimal tens/units and
// flags the special renderings.
//   bin_i     : field value, unsigned 0..127
//   tens_o    : bin_i div 10
//   units_o   : bin_i mod 10
//   is_dash_o : field equals DASH_CODE (takes priority over the range check)
//   is_err_o  : field above 99 and not the dash code
module seg_bin2dec #(
    parameter int DASH_CODE = 60
) (
    input  logic [6:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o,
    output logic       is_dash_o,
    output logic       is_err_o
);

    // Constant divisor: synthesis reduces this to a small multiply/shift net.
    assign tens_o    = 4'(bin_i / 7'd10);
    assign units_o   = 4'(bin_i % 7'd10);
    assign is_dash_o = (bin_i == 7'(DASH_CODE));
    assign is_err_o  = (bin_i > 7'd99) && !is_dash_o;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver -- multiplexed common-anode seven-segment scan driver.
// Each of N_FIELDS binary fields drives two digits (units on the even digit,
// tens on the odd one). Every digit slot opens with a dead-time window to
// suppress ghosting, then a 16-step PWM window sets brightness. Fields, DP
// and blink masks are latched once per frame so a frame is never torn.
//   clk, rst_n  : clock, asynchronous active-low reset
//   fields      : field k at bits [7k+6:7k]
//   dp_mask     : bit d lights the DP of digit d
//   blink_mask  : bit k blinks both digits of field k
//   brightness  : 0 = 1/16 duty .. 15 = full duty (sampled live)
//   dig_n       : active-low digit enables, at most one low
//   seg         : bit7 = DP, bits6:0 = g..a, active high
//   frame_start : one-cycle pulse at the start of digit 0's slot
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_FIELDS     = 3,
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 64,
    parameter int DASH_CODE    = 60,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7*N_FIELDS-1:0] fields,
    input  logic [2*N_FIELDS-1:0] dp_mask,
    input  logic [N_FIELDS-1:0]   blink_mask,
    input  logic [3:0]            brightness,
    output logic [2*N_FIELDS-1:0] dig_n,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int ND  = 2 * N_FIELDS;
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int DW  = $clog2(ND);
    localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    slot_state_e           state_q, state_d;
    logic [SCW-1:0]        sc_q, sc_d;
    logic [DW-1:0]         d_q, d_d;
    logic [3:0]            pwm_q, pwm_d;
    logic                  run_q;
    logic                  blink_phase_q, blink_phase_d;
    logic [BFW-1:0]        frame_cnt_q, frame_cnt_d;
    logic                  frame_start_q, frame_start_d;
    logic [ND-1:0]         dig_n_q, dig_n_d;
    logic [7:0]            seg_q, seg_d;

    // Per-frame snapshot of the display inputs.
    logic [7*N_FIELDS-1:0] fields_q;
    logic [ND-1:0]         dp_q;
    logic [N_FIELDS-1:0]   blink_q;

    logic [6:0]            field_sel;
    logic                  blink_sel;
    logic [3:0]            tens, units;
    logic                  is_dash, is_err;
    logic                  wrap;

    // Field and blink bit belonging to the digit currently in its slot.
    always_comb begin
        field_sel = '0;
        blink_sel = 1'b0;
        for (int k = 0; k < N_FIELDS; k++) begin
            if (int'(d_q >> 1) == k) begin
                field_sel = fields_q[7*k +: 7];
                blink_sel = blink_q[k];
            end
        end
    end

    seg_bin2dec #(
        .DASH_CODE (DASH_CODE)
    ) u_bin2dec (
        .bin_i     (field_sel),
        .tens_o    (tens),
        .units_o   (units),
        .is_dash_o (is_dash),
        .is_err_o  (is_err)
    );

    // Next-state and registered-output decision.
    always_comb begin
        logic [3:0] digit_val;
        logic [6:0] code7;
        logic       drive;

        sc_d          = sc_q + SCW'(1);
        d_d           = d_q;
        wrap          = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        dig_n_d       = '1;
        seg_d         = SEG_OFF;

        if (!run_q) begin
            // First cycle out of reset: hold slot 0 so this cycle opens the frame.
            sc_d = '0;
            d_d  = '0;
        end else if (sc_q == SCW'(SCAN_DIV - 1)) begin
            sc_d = '0;
            if (d_q == DW'(ND - 1)) begin
                d_d  = '0;
                wrap = 1'b1;
            end else begin
                d_d = d_q + DW'(1);
            end
        end

        frame_start_d = wrap || !run_q;

        state_d = (sc_d < SCW'(BLANK_CYCLES)) ? BLANK : ON;
        // Restarts at 0 on each BLANK->ON entry, free-runs mod 16 while ON.
        pwm_d   = (state_q == ON && state_d == ON) ? pwm_q + 4'd1 : 4'd0;

        if (wrap) begin
            if (frame_cnt_q == BFW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + BFW'(1);
            end
        end

        digit_val = d_q[0] ? tens : units;
        if (is_dash) begin
            code7 = SEG_DASH[6:0];
        end else if (is_err) begin
            code7 = SEG_ERR[6:0];
        end else begin
            code7 = seg_encode(digit_val);
        end

        drive = (state_q == ON) && (pwm_q <= brightness) &&
                !(blink_phase_q && blink_sel);
        if (drive) begin
            dig_n_d[d_q] = 1'b0;
            seg_d        = {dp_q[d_q], code7};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BLANK;
            sc_q          <= '0;
            d_q           <= '0;
            pwm_q         <= 4'd0;
            run_q         <= 1'b0;
            blink_phase_q <= 1'b0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            dig_n_q       <= '1;
            seg_q         <= SEG_OFF;
            fields_q      <= '0;
            dp_q          <= '0;
            blink_q       <= '0;
        end else begin
            state_q       <= state_d;
            sc_q          <= sc_d;
            d_q           <= d_d;
            pwm_q         <= pwm_d;
            run_q         <= 1'b1;
            blink_phase_q <= blink_phase_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            dig_n_q       <= dig_n_d;
            seg_q         <= seg_d;
            if (frame_start_q) begin
                fields_q <= fields;
                dp_q     <= dp_mask;
                blink_q  <= blink_mask;
            end
        end
    end

    assign dig_n       = dig_n_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule
